// File: rtl/spart_bus_responder.sv
// SPART host bus responder: data/status/divisor registers, TX handshake and baud tick generator.
// Build option: define SPART_STATUS_READ_EN to make {6'b0, tbr, rda} readable at ioaddr 01.
module spart_bus_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       baud_en
);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_PULSE,
    TX_WAIT
  } tx_state_t;

  tx_state_t   tx_state, tx_next;
  logic [7:0]  rx_buf;
  logic [15:0] div;
  logic [15:0] baud_cnt;
  logic        busy_q;
  logic        busy_fall;
  logic        rd_data;
  logic        wr_data;
  logic        wr_div_lo;
  logic        wr_div_hi;
  logic        bus_oe;
  logic [7:0]  bus_out;

  assign rd_data   = iorw  && (ioaddr == 2'b00);
  assign wr_data   = !iorw && (ioaddr == 2'b00);
  assign wr_div_lo = !iorw && (ioaddr == 2'b10);
  assign wr_div_hi = !iorw && (ioaddr == 2'b11);
  assign busy_fall = busy_q && !tx_busy;

`ifdef SPART_STATUS_READ_EN
  logic rd_stat;
  assign rd_stat = iorw && (ioaddr == 2'b01);
`endif

  always_comb begin
    bus_oe  = rd_data;
    bus_out = rx_buf;
`ifdef SPART_STATUS_READ_EN
    if (rd_stat) begin
      bus_oe  = 1'b1;
      bus_out = {6'b0, tbr, rda};
    end
`endif
  end

  assign databus = bus_oe ? bus_out : 8'hzz;

  // Receive side: a fresh byte always wins over the read-clear of rda.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf <= '0;
      rda    <= 1'b0;
    end else if (rx_valid) begin
      rx_buf <= rx_data;
      rda    <= 1'b1;
    end else if (rd_data) begin
      rda    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_data  <= '0;
      busy_q   <= 1'b0;
    end else begin
      tx_state <= tx_next;
      busy_q   <= tx_busy;
      if ((tx_state == TX_IDLE) && wr_data) tx_data <= databus;
    end
  end

  // LOAD holds one cycle so tx_start lands on the edge after the capture.
  always_comb begin
    tx_next  = tx_state;
    tbr      = 1'b0;
    tx_start = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tbr = 1'b1;
        if (wr_data) tx_next = TX_LOAD;
      end
      TX_LOAD:  tx_next = TX_PULSE;
      TX_PULSE: begin
        tx_start = 1'b1;
        tx_next  = busy_fall ? TX_IDLE : TX_WAIT;
      end
      TX_WAIT:  if (busy_fall) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // High-byte write restarts the count so the new rate applies immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= 16'h00A2;
      baud_cnt <= 16'h00A2;
      baud_en  <= 1'b0;
    end else begin
      if (wr_div_lo) div[7:0] <= databus;
      if (wr_div_hi) begin
        div[15:8] <= databus;
        baud_cnt  <= {databus, div[7:0]};
        baud_en   <= 1'b0;
      end else if (baud_cnt == 16'h0000) begin
        baud_cnt  <= div;
        baud_en   <= 1'b1;
      end else begin
        baud_cnt  <= baud_cnt - 16'd1;
        baud_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spart_bus_responder.sv
// Testbench for spart_bus_responder: directed vector table, hand sequences, random run vs model.
`timescale 1ns/1ps
module tb_spart_bus_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iorw = 1'b1;
  logic [1:0] ioaddr = 2'b10;
  logic [7:0] wdat = 8'h00;
  wire  [7:0] databus;
  logic       rda, tbr, tx_start, baud_en;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SPART_STATUS_READ_EN
  localparam logic [7:0] STAT_EXP = 8'h03;
`else
  localparam logic [7:0] STAT_EXP = 8'hFF;
`endif

  spart_bus_responder dut (
    .clk(clk), .rst(rst), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .baud_en(baud_en)
  );

  // Host drives only for writes; pullups make an undriven bus read as FF.
  assign databus = !iorw ? wdat : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (databus[gi]);
  end

  always #5 clk = ~clk;

  // Reference model
  int         cyc, next_tick, m_start_cyc;
  logic [15:0] m_div;
  logic [7:0] m_rx_buf, m_tx_data;
  logic       m_rda, m_tbr, m_baud, m_start, m_prev_busy;

  task automatic model_reset();
    cyc = 0; m_div = 16'h00A2; next_tick = 16'h00A2 + 1;
    m_rx_buf = 8'h00; m_tx_data = 8'h00; m_rda = 1'b0; m_tbr = 1'b1;
    m_baud = 1'b0; m_start = 1'b0; m_start_cyc = -10; m_prev_busy = 1'b0;
  endtask

  task automatic model_edge();
    cyc++;
    if (!iorw && ioaddr == 2'd3) begin
      m_div[15:8] = wdat;
      next_tick = cyc + int'(m_div) + 1;
      m_baud = 1'b0;
    end else if (cyc == next_tick) begin
      m_baud = 1'b1;
      next_tick = cyc + int'(m_div) + 1;
    end else m_baud = 1'b0;
    if (!iorw && ioaddr == 2'd2) m_div[7:0] = wdat;
    m_start = (cyc == m_start_cyc);
    if (m_tbr) begin
      if (!iorw && ioaddr == 2'd0) begin
        m_tx_data = wdat; m_tbr = 1'b0; m_start_cyc = cyc + 1;
      end
    end else if (cyc > m_start_cyc && m_prev_busy && !tx_busy) m_tbr = 1'b1;
    m_prev_busy = tx_busy;
    if (rx_valid) begin
      m_rx_buf = rx_data; m_rda = 1'b1;
    end else if (iorw && ioaddr == 2'd0) m_rda = 1'b0;
  endtask

  function automatic logic [7:0] exp_bus();
    if (ioaddr == 2'd0) return m_rx_buf;
`ifdef SPART_STATUS_READ_EN
    if (ioaddr == 2'd1) return {6'b0, m_tbr, m_rda};
`endif
    return 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("rda", rda, m_rda);
    chk("tbr", tbr, m_tbr);
    chk("tx_start", tx_start, m_start);
    chk("tx_data", tx_data, m_tx_data);
    chk("baud_en", baud_en, m_baud);
  endtask

  task automatic step();
    #1;
    if (iorw === 1'b1) chk("databus", databus, exp_bus());
    @(posedge clk);
    model_edge();
    #1;
    chk_outputs();
  endtask

  task automatic do_reset();
    iorw = 1'bx; ioaddr = 2'bxx; wdat = 8'hxx; rx_valid = 1'b0; tx_busy = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk_outputs();
    repeat (3) @(posedge clk);
    #1;
    iorw = 1'b1; ioaddr = 2'd2; wdat = 8'h00;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       iorw;
    logic [1:0] addr;
    logic [7:0] wdat;
    logic       rxv;
    logic [7:0] rxd;
    logic       busy;
    logic       bus_chk;
    logic [7:0] exp_bus;
    logic       exp_rda;
    logic       exp_tbr;
    logic       exp_start;
  } vec_t;

  function automatic vec_t mk(logic rw, logic [1:0] a, logic [7:0] w, logic rv, logic [7:0] rd,
                              logic b, logic bc, logic [7:0] eb, logic er, logic et, logic es);
    vec_t v;
    v.iorw = rw; v.addr = a; v.wdat = w; v.rxv = rv; v.rxd = rd; v.busy = b;
    v.bus_chk = bc; v.exp_bus = eb; v.exp_rda = er; v.exp_tbr = et; v.exp_start = es;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int first;
    tbl[0]  = mk(0, 2'd0, 8'h5A, 0, 8'h00, 0, 0, 8'h00,   0, 0, 0);
    tbl[1]  = mk(0, 2'd0, 8'hA5, 0, 8'h00, 0, 0, 8'h00,   0, 0, 1);
    tbl[2]  = mk(1, 2'd2, 8'h00, 0, 8'h00, 1, 1, 8'hFF,   0, 0, 0);
    tbl[3]  = mk(1, 2'd2, 8'h00, 0, 8'h00, 1, 1, 8'hFF,   0, 0, 0);
    tbl[4]  = mk(1, 2'd2, 8'h00, 0, 8'h00, 0, 1, 8'hFF,   0, 1, 0);
    tbl[5]  = mk(1, 2'd2, 8'h00, 1, 8'h3C, 0, 1, 8'hFF,   1, 1, 0);
    tbl[6]  = mk(1, 2'd0, 8'h00, 0, 8'h00, 0, 1, 8'h3C,   0, 1, 0);
    tbl[7]  = mk(1, 2'd0, 8'h00, 1, 8'h77, 0, 1, 8'h3C,   1, 1, 0);
    tbl[8]  = mk(1, 2'd0, 8'h00, 0, 8'h00, 0, 1, 8'h77,   0, 1, 0);
    tbl[9]  = mk(1, 2'd2, 8'h00, 1, 8'h11, 0, 1, 8'hFF,   1, 1, 0);
    tbl[10] = mk(1, 2'd1, 8'h00, 0, 8'h00, 0, 1, STAT_EXP, 1, 1, 0);
    tbl[11] = mk(0, 2'd1, 8'hEE, 0, 8'h00, 0, 0, 8'h00,   1, 1, 0);
    tbl[12] = mk(1, 2'd0, 8'h00, 0, 8'h00, 0, 1, 8'h11,   0, 1, 0);
    tbl[13] = mk(1, 2'd3, 8'h00, 0, 8'h00, 0, 1, 8'hFF,   0, 1, 0);

    #2;
    do_reset();
    chk("rst_rda", rda, 1'b0);
    chk("rst_tbr", tbr, 1'b1);

    // Directed TX/RX/status vectors
    for (int i = 0; i < 14; i++) begin
      iorw = tbl[i].iorw; ioaddr = tbl[i].addr; wdat = tbl[i].wdat;
      rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd; tx_busy = tbl[i].busy;
      #1;
      if (tbl[i].bus_chk) chk($sformatf("tbl%0d_bus", i), databus, tbl[i].exp_bus);
      step();
      chk($sformatf("tbl%0d_rda", i), rda, tbl[i].exp_rda);
      chk($sformatf("tbl%0d_tbr", i), tbr, tbl[i].exp_tbr);
      chk($sformatf("tbl%0d_start", i), tx_start, tbl[i].exp_start);
    end
    chk("tx_data_kept", tx_data, 8'h5A);
    rx_valid = 1'b0;

    // Divisor 3: ticks every 4 cycles counted from the high-byte write
    iorw = 1'b0; ioaddr = 2'd2; wdat = 8'h03; step();
    ioaddr = 2'd3; wdat = 8'h00; step();
    for (int k = 1; k <= 12; k++) begin
      iorw = 1'b1; ioaddr = 2'd2;
      step();
      chk($sformatf("div3_tick%0d", k), baud_en, (k % 4) == 0);
    end

    // Divisor 0x0010, start a transmit, reset during the tx_start cycle
    iorw = 1'b0; ioaddr = 2'd2; wdat = 8'h10; step();
    ioaddr = 2'd3; wdat = 8'h00; step();
    ioaddr = 2'd0; wdat = 8'hC3; step();
    iorw = 1'b1; ioaddr = 2'd2; step();
    chk("pre_rst_start", tx_start, 1'b1);
    do_reset();
    chk("midtx_rst_tbr", tbr, 1'b1);
    chk("midtx_rst_start", tx_start, 1'b0);
    chk("midtx_rst_data", tx_data, 8'h00);
    first = 0;
    for (int k = 1; k <= 200; k++) begin
      iorw = 1'b1; ioaddr = 2'd2;
      step();
      if (baud_en && first == 0) first = k;
      if (first != 0) break;
    end
    chk("first_tick_after_rst", 16'(first), 16'd163);
    chk("post_rst_tbr", tbr, 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      iorw = 1'($urandom_range(0, 1));
      ioaddr = 2'($urandom_range(0, 3));
      wdat = 8'($urandom);
      if (!iorw && ioaddr == 2'd3) wdat = 8'($urandom_range(0, 1));
      if (!iorw && ioaddr == 2'd2 && $urandom_range(0, 1) == 0) wdat = 8'($urandom_range(0, 15));
      rx_valid = ($urandom_range(0, 7) == 0);
      rx_data = 8'($urandom);
      if ($urandom_range(0, 5) == 0) tx_busy = ~tx_busy;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
